pipe_conv_encoder: RTL and testbench
====================================

PIPE_CONV_ENCODER -- requirements
Module: pipe_conv_encoder

Interface
REQ-001 Parameter FRAME_BYTES, default 7: data bytes per frame before the tail word; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  data_in holds a valid byte this cycle.
REQ-005 in_ready  output  1  encoder accepts data_in this cycle.
REQ-006 data_in  input  8  information byte; bit 7 is encoded first.
REQ-007 out_valid  output  1  data_out holds a valid encoded word.
REQ-008 out_ready  input  1  downstream (decoder input side) takes data_out this cycle.
REQ-009 data_out  output  16  8 code pairs; pair for bit i of the source byte is on data_out[2i+1:2i], so data_out[15:14] is the first pair.
REQ-010 data_id  output  3  index of the current word within its frame, 0..FRAME_BYTES.
REQ-011 out_last  output  1  data_out is the frame tail word.

Function
REQ-012 Code SHALL be rate 1/2, K=3, generators g0=111 and g1=101 (octal 7,5), with encoder state {s1,s0}, where s1 is the most recent bit.
REQ-013 For each input bit b, the encoder SHALL emit the pair {c0,c1} with c0=b^s1^s0 and c1=b^s0, then update s0<=s1 and s1<=b; all 8 bits of a byte SHALL be processed in one cycle.
REQ-014 Encoder state SHALL carry across bytes within a frame and SHALL be 00 at the start of every frame.
REQ-015 The FSM SHALL have two states: DATA and TAIL.
REQ-016 In DATA, in_ready SHALL equal (!out_valid || out_ready).
REQ-017 A byte is accepted when in_valid && in_ready; on acceptance the module SHALL register the encoded word and its data_id, and set out_valid the next cycle (latency 1).
REQ-018 The byte counter SHALL increment per accepted byte; acceptance of byte FRAME_BYTES-1 (0-based) SHALL move the FSM to TAIL.
REQ-019 In TAIL, in_ready SHALL be 0.
REQ-020 In TAIL, when the output slot is free (!out_valid || out_ready), the module SHALL load the tail word, which is the encoding of 8 zero bits from the current state.
REQ-021 Loading the tail word SHALL set out_last=1 and data_id=FRAME_BYTES, reset the encoder state to 00 and the counter to 0, and return the FSM to DATA.
REQ-022 When out_valid && !out_ready, data_out, data_id and out_last SHALL hold stable and no input SHALL be accepted.
REQ-023 Simultaneous transfer (out_ready=1 while a new byte or tail word loads) SHALL replace the output word with no bubble; full throughput is one word per cycle.
REQ-024 out_valid SHALL drop the cycle after a transfer when no new word loads.
REQ-025 in_valid without in_ready SHALL leave all state unchanged; in_valid is not required to be held high.

Reset
REQ-026 On rst low, the module SHALL immediately set out_valid=0, data_out=0, data_id=0, out_last=0, encoder state 00, counter 0, FSM DATA.
REQ-027 While rst is low, in_ready SHALL be 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first byte accepted after reset starts a new frame at data_id 0.
REQ-029 Reset release SHALL take effect synchronously to clk; the first acceptance is possible in the first cycle after deassertion.

Verification
REQ-030 Reset check: assert rst low mid-frame -> out_valid=0, data_out=0x0000, data_id=0 immediately; the next frame starts at data_id 0.
REQ-031 Impulse: state 00, data_in=0x80 -> data_out=0xEC00, data_id=0 one cycle later.
REQ-032 All-ones plus tail (FRAME_BYTES=1): data_in=0xFF -> 0xDAAA with data_id 0, then 0x7000 with out_last=1 and data_id 1; the next byte 0x80 -> 0xEC00.
REQ-033 Full frame (FRAME_BYTES=7), in_valid and out_ready held 1 -> 8 consecutive words with data_id 0..7 and one in_ready=0 cycle during TAIL.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> data_out stable, in_ready=0, no byte lost or duplicated after release.
REQ-035 Loopback: random frames through this module into PipeViterbi -> decoded bytes match the source bytes once decoder latency is accounted for.

Source files
------------

// File: rtl/pipe_conv_encoder.sv
// Rate-1/2 K=3 (7,5) convolutional encoder, one byte per cycle.
// Frames of FRAME_BYTES data words are closed by a zero-flush tail word.
module pipe_conv_encoder #(
  parameter int FRAME_BYTES = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] data_out,
  output logic [2:0]  data_id,
  output logic        out_last
);

  typedef enum logic {DATA, TAIL} state_t;

  localparam logic [2:0] LAST    = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] ID_TAIL = 3'(FRAME_BYTES);

  state_t      state;
  logic [1:0]  enc_st;
  logic [2:0]  cnt;
  logic        slot_free;
  logic        accept;
  logic        load_tail;
  logic [7:0]  src;
  logic [7:0]  sr;
  logic        s1;
  logic        s0;
  logic [15:0] word;
  logic [1:0]  st_next;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rst && (state == DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign load_tail = (state == TAIL) && slot_free;

  // The tail word is the same encoder fed with eight zero bits.
  always_comb begin
    src  = (state == TAIL) ? 8'h00 : data_in;
    sr   = src;
    s1   = enc_st[1];
    s0   = enc_st[0];
    word = '0;
    for (int i = 0; i < 8; i++) begin
      word = {word[13:0], sr[7] ^ s1 ^ s0, sr[7] ^ s0};
      s0   = s1;
      s1   = sr[7];
      sr   = {sr[6:0], 1'b0};
    end
    st_next = {s1, s0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DATA;
      enc_st    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      data_id   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      data_out  <= word;
      data_id   <= cnt;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      enc_st    <= st_next;
      cnt       <= cnt + 3'd1;
      if (cnt == LAST)
        state <= TAIL;
    end else if (load_tail) begin
      data_out  <= word;
      data_id   <= ID_TAIL;
      out_last  <= 1'b1;
      out_valid <= 1'b1;
      enc_st    <= '0;
      cnt       <= '0;
      state     <= DATA;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_conv_encoder.sv
// Bench for pipe_conv_encoder: directed vectors plus random
// traffic against a generator-polynomial model and a loopback decode.
module tb_pipe_conv_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv, ir, ov, ordy, ol;
  logic [7:0]  din;
  logic [15:0] dout;
  logic [2:0]  did;
  logic        iv1, ir1, ov1, ordy1, ol1;
  logic [7:0]  din1;
  logic [15:0] dout1;
  logic [2:0]  did1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] w;
    logic [2:0]  id;
    logic        last;
  } exp_t;

  exp_t       exq[$];
  logic [7:0] srcq[$];
  logic [1:0] m_hist;
  int         m_cnt;
  logic [1:0] dec_h;

  always #5 clk = ~clk;

  pipe_conv_encoder dut7 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .data_in(din),
    .out_valid(ov), .out_ready(ordy), .data_out(dout),
    .data_id(did), .out_last(ol)
  );

  pipe_conv_encoder #(.FRAME_BYTES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .data_in(din1),
    .out_valid(ov1), .out_ready(ordy1), .data_out(dout1),
    .data_id(did1), .out_last(ol1)
  );

  // Window {two-ago, previous, current}; c0 = parity(win & 111), c1 = parity(win & 101).
  function automatic logic [17:0] ref_enc(input logic [7:0] b, input logic [1:0] hist);
    logic [2:0]  win;
    logic [15:0] w;
    logic [7:0]  bb;
    win = {1'b0, hist};
    w   = '0;
    bb  = b;
    for (int k = 0; k < 8; k++) begin
      win = {win[1:0], bb[7]};
      w   = {w[13:0], ^(win & 3'b111), ^(win & 3'b101)};
      bb  = {bb[6:0], 1'b0};
    end
    return {win[1:0], w};
  endfunction

  // Hard-decision inverse: b = c1 ^ (bit two positions back).
  function automatic logic [9:0] loop_dec(input logic [15:0] w, input logic [1:0] h);
    logic [15:0] ww;
    logic [7:0]  by;
    logic [1:0]  hh;
    logic        bt;
    ww = w;
    hh = h;
    by = '0;
    for (int k = 0; k < 8; k++) begin
      bt = ww[14] ^ hh[1];
      hh = {hh[0], bt};
      by = {by[6:0], bt};
      ww = {ww[13:0], 2'b00};
    end
    return {hh, by};
  endfunction

  task automatic model_reset();
    exq.delete();
    srcq.delete();
    m_hist = '0;
    m_cnt  = 0;
    dec_h  = '0;
  endtask

  task automatic model_accept(input logic [7:0] b, input int frame);
    logic [17:0] r;
    r = ref_enc(b, m_hist);
    m_hist = r[17:16];
    exq.push_back({r[15:0], 3'(m_cnt), 1'b0});
    srcq.push_back(b);
    m_cnt++;
    if (m_cnt == frame) begin
      r = ref_enc(8'h00, m_hist);
      exq.push_back({r[15:0], 3'(frame), 1'b1});
      m_hist = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    iv = 0; ordy = 0; din = '0;
    iv1 = 0; ordy1 = 0; din1 = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_impulse();
    do_reset();
    iv = 1; din = 8'h80; ordy = 0;
    @(negedge clk);
    n_cmp++;
    if (ir !== 1'b1) begin
      n_err++; $display("FAIL impulse_ready: got %b want 1", ir);
    end
    @(posedge clk); #1 iv = 0;
    @(negedge clk);
    n_cmp++;
    if ({ov, dout, did, ol} !== {1'b1, 16'hEC00, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL impulse_word: got v=%b %h id=%0d last=%b want v=1 ec00 id=0 last=0",
               ov, dout, did, ol);
    end
    ordy = 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_err++; $display("FAIL valid_drop: got %b want 0", ov);
    end
  endtask

  task automatic test_reset();
    do_reset();
    iv = 1; din = 8'hFF; ordy = 1;
    @(posedge clk); #1 din = 8'h80;
    @(posedge clk); #1 iv = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ov, dout, did, ol, ir} !== {1'b0, 16'h0000, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b %h id=%0d last=%b rdy=%b want 0 0000 0 0 0",
               ov, dout, did, ol, ir);
    end
    n_cmp++;
    if ({ov1, dout1, ir1} !== {1'b0, 16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state_f1: got v=%b %h rdy=%b want 0 0000 0", ov1, dout1, ir1);
    end
    @(posedge clk); #1 rst = 1'b1;
    iv = 1; din = 8'h80;
    @(negedge clk);
    n_cmp++;
    if (ir !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", ir);
    end
    @(posedge clk); #1 iv = 0;
    @(negedge clk);
    n_cmp++;
    if ({ov, dout, did} !== {1'b1, 16'hEC00, 3'd0}) begin
      n_err++;
      $display("FAIL reset_new_frame: got v=%b %h id=%0d want v=1 ec00 id=0", ov, dout, did);
    end
  endtask

  task automatic test_tail_one();
    do_reset();
    iv1 = 1; din1 = 8'hFF; ordy1 = 1;
    @(negedge clk);
    n_cmp++;
    if (ir1 !== 1'b1) begin
      n_err++; $display("FAIL tail1_ready0: got %b want 1", ir1);
    end
    @(posedge clk); #1 din1 = 8'h80;
    @(negedge clk);
    n_cmp++;
    if ({dout1, did1, ol1, ir1} !== {16'hDAAA, 3'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL tail1_data: got %h id=%0d last=%b rdy=%b want daaa id=0 last=0 rdy=0",
               dout1, did1, ol1, ir1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({ov1, dout1, did1, ol1, ir1} !== {1'b1, 16'h7000, 3'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL tail1_tail: got v=%b %h id=%0d last=%b rdy=%b want 1 7000 1 1 1",
               ov1, dout1, did1, ol1, ir1);
    end
    @(posedge clk); #1 iv1 = 0;
    @(negedge clk);
    n_cmp++;
    if ({dout1, did1, ol1} !== {16'hEC00, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL tail1_next: got %h id=%0d last=%b want ec00 id=0 last=0",
               dout1, did1, ol1);
    end
  endtask

  task automatic test_full_frame();
    int   words;
    int   lows;
    exp_t e;
    words = 0;
    lows  = 0;
    model_reset();
    do_reset();
    iv = 1; ordy = 1; din = 8'($urandom);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (ov && ordy) begin
        words++;
        e = exq.pop_front();
        n_cmp++;
        if ({dout, did, ol} !== {e.w, e.id, e.last}) begin
          n_err++;
          $display("FAIL full_word: got %h id=%0d last=%b want %h id=%0d last=%b",
                   dout, did, ol, e.w, e.id, e.last);
        end
      end
      if (!ir) lows++;
      if (iv && ir) model_accept(din, 7);
      @(posedge clk); #1 din = 8'($urandom);
    end
    iv = 0;
    n_cmp++;
    if (words != 8) begin
      n_err++; $display("FAIL full_count: got %0d words want 8", words);
    end
    n_cmp++;
    if (lows != 1) begin
      n_err++; $display("FAIL full_ready_low: got %0d cycles want 1", lows);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  b0, b1;
    logic [17:0] r0, r1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    r0 = ref_enc(b0, 2'b00);
    r1 = ref_enc(b1, r0[17:16]);
    do_reset();
    iv = 1; din = b0; ordy = 0;
    @(posedge clk); #1 din = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov, ir, dout, did} !== {1'b1, 1'b0, r0[15:0], 3'd0}) begin
        n_err++;
        $display("FAIL bp_hold: got v=%b rdy=%b %h id=%0d want v=1 rdy=0 %h id=0",
                 ov, ir, dout, did, r0[15:0]);
      end
      @(posedge clk); #1 din = 8'($urandom);
    end
    din = b1; ordy = 1;
    @(negedge clk);
    n_cmp++;
    if ({ir, dout} !== {1'b1, r0[15:0]}) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b %h want rdy=1 %h", ir, dout, r0[15:0]);
    end
    @(posedge clk); #1 iv = 0;
    @(negedge clk);
    n_cmp++;
    if ({ov, dout, did} !== {1'b1, r1[15:0], 3'd1}) begin
      n_err++;
      $display("FAIL bp_next: got v=%b %h id=%0d want v=1 %h id=1", ov, dout, did, r1[15:0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: got v=%b want 0", ov);
    end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [9:0] d;
    logic [7:0] s;
    model_reset();
    do_reset();
    for (int c = 0; c < 630; c++) begin
      if (c < 600) begin
        iv   = ($urandom_range(0, 3) != 0);
        din  = 8'($urandom);
        ordy = ($urandom_range(0, 3) != 0);
      end else begin
        iv   = 0;
        ordy = 1;
      end
      @(negedge clk);
      if (ov && ordy) begin
        n_cmp++;
        if (exq.size() == 0) begin
          n_err++; $display("FAIL rand_extra: got word %h want none", dout);
        end else begin
          e = exq.pop_front();
          if ({dout, did, ol} !== {e.w, e.id, e.last}) begin
            n_err++;
            $display("FAIL rand_word: got %h id=%0d last=%b want %h id=%0d last=%b",
                     dout, did, ol, e.w, e.id, e.last);
          end
          if (e.last) begin
            dec_h = '0;
          end else begin
            d = loop_dec(dout, dec_h);
            dec_h = d[9:8];
            s = srcq.pop_front();
            n_cmp++;
            if (d[7:0] !== s) begin
              n_err++;
              $display("FAIL loopback: got %h want %h", d[7:0], s);
            end
          end
        end
      end
      if (iv && ir) model_accept(din, 7);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exq.size() != 0) begin
      n_err++; $display("FAIL rand_pending: got %0d words left want 0", exq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_impulse();
    test_tail_one();
    test_full_frame();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
